// File: rtl/bresenham_line_pkg.sv
// Shared types and helpers for the line rasteriser and the VGA line overlay.
package hector_slam_pkg;

   localparam int COORD_WIDTH = 10;

   typedef logic [COORD_WIDTH-1:0]        coord_t;
   typedef logic signed [COORD_WIDTH+1:0] err_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      STEP  = 2'd2
   } bresenham_state_t;

   typedef struct packed {
      err_t mag;
      logic pos;   // 1 when stepping from a towards b increments the coordinate
   } diff_sign_t;

   function automatic diff_sign_t abs_diff_sign(coord_t a, coord_t b);
      diff_sign_t r;
      err_t       ea;
      err_t       eb;
      ea    = $signed({2'b00, a});
      eb    = $signed({2'b00, b});
      r.pos = (a < b);
      r.mag = r.pos ? (eb - ea) : (ea - eb);
      return r;
   endfunction

endpackage

// File: rtl/bresenham_line_if.sv
// Request and cell-stream signals between the control unit, the rasteriser and the occupancy stage.
interface bresenham_line_if;
   import hector_slam_pkg::*;

   logic   bresenham_start;
   coord_t x0;
   coord_t y0;
   coord_t x1;
   coord_t y1;
   logic   bresenham_busy;
   logic   cell_valid;
   logic   cell_ready;
   coord_t cell_x;
   coord_t cell_y;
   logic   cell_last;

   modport master (
      output bresenham_start, x0, y0, x1, y1, cell_ready,
      input  bresenham_busy, cell_valid, cell_x, cell_y, cell_last
   );

   modport slave (
      input  bresenham_start, x0, y0, x1, y1, cell_ready,
      output bresenham_busy, cell_valid, cell_x, cell_y, cell_last
   );

endinterface

// File: rtl/bresenham_line.sv
// Bresenham rasteriser: emits every cell from origin to endpoint inclusive, endpoint tagged last.
//
// state | meaning
// IDLE  | waiting for bresenham_start; origin/endpoint latched on accept
// SETUP | derive dx, dy, step directions and initial error
// STEP  | present current cell; advance on each accepted non-last cell
module bresenham_line
   import hector_slam_pkg::*;
(
   input logic             clock,
   input logic             reset,
   bresenham_line_if.slave line_if
);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_SETUP = SETUP;
   localparam logic [1:0] S_STEP  = STEP;

   logic [1:0] state_q, state_d;
   coord_t     x_q, x_d;
   coord_t     y_q, y_d;
   coord_t     xe_q, xe_d;
   coord_t     ye_q, ye_d;
   err_t       dx_q, dx_d;
   err_t       dy_q, dy_d;
   err_t       err_q, err_d;
   logic       sx_pos_q, sx_pos_d;
   logic       sy_pos_q, sy_pos_d;

   diff_sign_t ds_x;
   diff_sign_t ds_y;
   err_t       e2;
   err_t       err_n;
   logic       at_end;
   logic       valid;

   assign valid  = (state_q == S_STEP);
   assign at_end = (x_q == xe_q) && (y_q == ye_q);

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      xe_d     = xe_q;
      ye_d     = ye_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      err_d    = err_q;
      sx_pos_d = sx_pos_q;
      sy_pos_d = sy_pos_q;
      ds_x     = abs_diff_sign(x_q, xe_q);
      ds_y     = abs_diff_sign(y_q, ye_q);
      e2       = err_q <<< 1;
      err_n    = err_q;

      case (state_q)
         S_IDLE: begin
            if (line_if.bresenham_start) begin
               x_d     = line_if.x0;
               y_d     = line_if.y0;
               xe_d    = line_if.x1;
               ye_d    = line_if.y1;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            dx_d     = ds_x.mag;
            dy_d     = -ds_y.mag;
            sx_pos_d = ds_x.pos;
            sy_pos_d = ds_y.pos;
            err_d    = ds_x.mag - ds_y.mag;
            state_d  = S_STEP;
         end
         S_STEP: begin
            if (line_if.cell_ready) begin
               if (at_end) begin
                  state_d = S_IDLE;
               end else begin
                  // Both tests use the error from before this step, so diagonal moves update both axes.
                  if (e2 >= dy_q) begin
                     err_n = err_n + dy_q;
                     x_d   = sx_pos_q ? (x_q + coord_t'(1)) : (x_q - coord_t'(1));
                  end
                  if (e2 <= dx_q) begin
                     err_n = err_n + dx_q;
                     y_d   = sy_pos_q ? (y_q + coord_t'(1)) : (y_q - coord_t'(1));
                  end
                  err_d = err_n;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         x_q      <= '0;
         y_q      <= '0;
         xe_q     <= '0;
         ye_q     <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         err_q    <= '0;
         sx_pos_q <= 1'b0;
         sy_pos_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         xe_q     <= xe_d;
         ye_q     <= ye_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         err_q    <= err_d;
         sx_pos_q <= sx_pos_d;
         sy_pos_q <= sy_pos_d;
      end
   end

   assign line_if.bresenham_busy = (state_q != S_IDLE);
   assign line_if.cell_valid     = valid;
   assign line_if.cell_x         = x_q;
   assign line_if.cell_y         = y_q;
   assign line_if.cell_last      = valid && at_end;

endmodule

// File: tb/tb_bresenham_line.sv
// Self-checking bench for bresenham_line: directed rays, backpressure, reset cases and random rays.
module tb_bresenham_line;
   import hector_slam_pkg::*;

   logic clock = 1'b0;
   logic reset;

   bresenham_line_if bif();

   bresenham_line dut (
      .clock   (clock),
      .reset   (reset),
      .line_if (bif.slave)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   int exp_x[$];
   int exp_y[$];

   function automatic int iabs(int v);
      return (v < 0) ? -v : v;
   endfunction

   // Reference ray as a list of cells, computed with unbounded integers.
   function automatic void build_model(int x0, int y0, int x1, int y1);
      int dx, dy, sx, sy, err, e2, x, y;
      exp_x.delete();
      exp_y.delete();
      dx  = iabs(x1 - x0);
      dy  = -iabs(y1 - y0);
      sx  = (x0 < x1) ? 1 : -1;
      sy  = (y0 < y1) ? 1 : -1;
      err = dx + dy;
      x   = x0;
      y   = y0;
      for (int guard = 0; guard < 4096; guard++) begin
         exp_x.push_back(x);
         exp_y.push_back(y);
         if (x == x1 && y == y1) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += sx; end
         if (e2 <= dx) begin err += dx; y += sy; end
      end
   endfunction

   task automatic run_ray(input int x0, input int y0, input int x1, input int y1,
                          input int ready_pct, input int stall_idx, input int stall_len,
                          input int inject_at, input string name);
      int     idx, cycles, stall_cnt, budget, n, span;
      logic   rdy, prev_stall, injected;
      coord_t px, py;
      logic   pl;
      build_model(x0, y0, x1, y1);
      n      = exp_x.size();
      span   = (iabs(x1 - x0) > iabs(y1 - y0)) ? iabs(x1 - x0) : iabs(y1 - y0);
      budget = n * 20 + 50;
      @(negedge clock);
      bif.x0 = coord_t'(x0);
      bif.y0 = coord_t'(y0);
      bif.x1 = coord_t'(x1);
      bif.y1 = coord_t'(y1);
      bif.bresenham_start = 1'b1;
      bif.cell_ready = 1'b0;
      @(negedge clock);
      bif.bresenham_start = 1'b0;
      bif.x0 = coord_t'($urandom);
      bif.y0 = coord_t'($urandom);
      bif.x1 = coord_t'($urandom);
      bif.y1 = coord_t'($urandom);
      checks++;
      if (bif.bresenham_busy !== 1'b1 || bif.cell_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s setup: busy=%0b valid=%0b, required busy=1 valid=0",
                  name, bif.bresenham_busy, bif.cell_valid);
      end
      checks++;
      if (n != span + 1) begin
         errors++;
         $display("FAIL %s model_count: cells=%0d, required %0d", name, n, span + 1);
      end
      idx = 0; cycles = 0; stall_cnt = 0; prev_stall = 1'b0; injected = 1'b0;
      px = '0; py = '0; pl = 1'b0;
      while (idx < n && cycles < budget) begin
         @(negedge clock);
         cycles++;
         bif.bresenham_start = 1'b0;
         checks++;
         if (bif.cell_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s valid cycle %0d: valid=%0b, required 1", name, cycles, bif.cell_valid);
         end
         if (prev_stall) begin
            checks++;
            if (bif.cell_x !== px || bif.cell_y !== py || bif.cell_last !== pl) begin
               errors++;
               $display("FAIL %s hold: got (%0d,%0d,last=%0b), required (%0d,%0d,last=%0b)",
                        name, bif.cell_x, bif.cell_y, bif.cell_last, px, py, pl);
            end
         end
         if (bif.cell_valid === 1'b1) begin
            checks++;
            if (bif.cell_x !== coord_t'(exp_x[idx]) || bif.cell_y !== coord_t'(exp_y[idx]) ||
                bif.cell_last !== (idx == n - 1) || bif.bresenham_busy !== 1'b1) begin
               errors++;
               $display("FAIL %s cell %0d: got (%0d,%0d,last=%0b,busy=%0b), required (%0d,%0d,last=%0b,busy=1)",
                        name, idx, bif.cell_x, bif.cell_y, bif.cell_last, bif.bresenham_busy,
                        exp_x[idx], exp_y[idx], (idx == n - 1));
            end
            rdy = ($urandom_range(99) < ready_pct);
            if (idx == stall_idx && stall_cnt < stall_len) begin
               rdy = 1'b0;
               stall_cnt++;
            end
            if (idx == inject_at && !injected) begin
               injected = 1'b1;
               bif.bresenham_start = 1'b1;
               bif.x0 = coord_t'(x0 + 7);
               bif.y0 = coord_t'(y0 + 3);
               bif.x1 = coord_t'(x1 + 11);
               bif.y1 = coord_t'(y1 + 5);
            end
            bif.cell_ready = rdy;
            prev_stall = !rdy;
            px = bif.cell_x; py = bif.cell_y; pl = bif.cell_last;
            if (rdy) idx++;
         end else begin
            prev_stall = 1'b0;
         end
      end
      if (idx < n) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: accepted %0d cells, required %0d", name, idx, n);
      end
      if (ready_pct == 100 && stall_len == 0) begin
         checks++;
         if (cycles != n) begin
            errors++;
            $display("FAIL %s throughput: %0d cycles, required %0d", name, cycles, n);
         end
      end
      @(negedge clock);
      bif.bresenham_start = 1'b0;
      bif.cell_ready = 1'b0;
      checks++;
      if (bif.cell_valid !== 1'b0 || bif.bresenham_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s done: valid=%0b busy=%0b, required 0 0",
                  name, bif.cell_valid, bif.bresenham_busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      checks++;
      if (bif.bresenham_busy !== 1'b0 || bif.cell_valid !== 1'b0 || bif.cell_last !== 1'b0 ||
          bif.cell_x !== '0 || bif.cell_y !== '0) begin
         errors++;
         $display("FAIL reset_state: busy=%0b valid=%0b last=%0b x=%0d y=%0d, required all 0",
                  bif.bresenham_busy, bif.cell_valid, bif.cell_last, bif.cell_x, bif.cell_y);
      end
      reset = 1'b0;
   endtask

   task automatic test_horizontal();
      run_ray(0, 0, 3, 0, 100, -1, 0, -1, "horizontal");
   endtask

   task automatic test_steep_negative();
      run_ray(5, 5, 3, 0, 100, -1, 0, -1, "steep_negative");
   endtask

   task automatic test_backpressure();
      run_ray(0, 0, 2, 2, 100, 1, 3, -1, "backpressure");
   endtask

   task automatic test_degenerate_extremes();
      run_ray(7, 7, 7, 7, 100, -1, 0, -1, "degenerate");
      run_ray(0, 1023, 1023, 0, 100, -1, 0, -1, "extreme_diag");
      run_ray(1023, 0, 0, 1023, 80, -1, 0, -1, "extreme_diag_rev");
      run_ray(1023, 1023, 1023, 1023, 100, -1, 0, -1, "corner_point");
   endtask

   task automatic test_start_while_busy();
      run_ray(0, 0, 9, 4, 100, -1, 0, 2, "start_while_busy");
   endtask

   task automatic test_reset_mid_ray();
      int cycles;
      @(negedge clock);
      bif.x0 = 10'd0; bif.y0 = 10'd0; bif.x1 = 10'd9; bif.y1 = 10'd0;
      bif.bresenham_start = 1'b1;
      bif.cell_ready = 1'b1;
      @(negedge clock);
      bif.bresenham_start = 1'b0;
      cycles = 0;
      while (!(bif.cell_valid === 1'b1 && bif.cell_x === 10'd2) && cycles < 50) begin
         @(negedge clock);
         cycles++;
      end
      if (cycles >= 50) begin
         checks++;
         errors++;
         $display("FAIL reset_mid_ray timeout: third cell x=%0d never seen", 2);
      end
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (bif.cell_valid !== 1'b0 || bif.bresenham_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_ray: valid=%0b busy=%0b, required 0 0",
                  bif.cell_valid, bif.bresenham_busy);
      end
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         checks++;
         if (bif.cell_valid !== 1'b0 || bif.bresenham_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ray_quiet %0d: valid=%0b busy=%0b, required 0 0",
                     i, bif.cell_valid, bif.bresenham_busy);
         end
      end
      bif.cell_ready = 1'b0;
      run_ray(2, 6, 8, 1, 100, -1, 0, -1, "after_reset");
   endtask

   task automatic test_reset_with_start();
      @(negedge clock);
      reset = 1'b1;
      bif.bresenham_start = 1'b1;
      bif.x0 = 10'd1; bif.y0 = 10'd1; bif.x1 = 10'd5; bif.y1 = 10'd5;
      @(negedge clock);
      reset = 1'b0;
      bif.bresenham_start = 1'b0;
      checks++;
      if (bif.bresenham_busy !== 1'b0 || bif.cell_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_with_start: busy=%0b valid=%0b, required 0 0",
                  bif.bresenham_busy, bif.cell_valid);
      end
      repeat (2) @(negedge clock);
      checks++;
      if (bif.bresenham_busy !== 1'b0 || bif.cell_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_with_start_dropped: busy=%0b valid=%0b, required 0 0",
                  bif.bresenham_busy, bif.cell_valid);
      end
   endtask

   task automatic test_random();
      int ax, ay, bx, by;
      for (int i = 0; i < 30; i++) begin
         ax = $urandom_range(31); ay = $urandom_range(31);
         bx = $urandom_range(31); by = $urandom_range(31);
         run_ray(ax, ay, bx, by, 60, -1, 0, -1, "random_small");
      end
      for (int i = 0; i < 3; i++) begin
         ax = $urandom_range(1023); ay = $urandom_range(1023);
         bx = $urandom_range(1023); by = $urandom_range(1023);
         run_ray(ax, ay, bx, by, 90, -1, 0, -1, "random_full");
      end
   endtask

   initial begin
      reset = 1'b1;
      bif.bresenham_start = 1'b0;
      bif.cell_ready = 1'b0;
      bif.x0 = '0; bif.y0 = '0; bif.x1 = '0; bif.y1 = '0;
      test_reset();
      test_horizontal();
      test_steep_negative();
      test_backpressure();
      test_degenerate_extremes();
      test_start_while_busy();
      test_reset_mid_ray();
      test_reset_with_start();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
